sdio_cmd_master: RTL
====================

Name: sdio_cmd_master

Overview:
- Wishbone pipelined bus master directly upstream of the SDIO controller's control port.
- Accepts a single command request (argument plus command word) from a local sequencer or soft-core.
- Writes the argument and command registers, polls the command register until the busy bit clears or a timeout expires, then reads the response register.
- Returns status and response through a valid/ready handshake, so boot/init logic can drive the card without a CPU.

Parameters:
- MW, 32, Wishbone data width; request and response words are MW bits.
- ADDR_CMD, 3'd0, word address of the command/status register.
- ADDR_ARG, 3'd1, word address of the argument register.
- ADDR_RSP, 3'd1, word address read back for the response; it is the argument register after completion.
- BUSY_BIT, 14, bit index in the command register that is 1 while a command is in flight.
- ERR_BIT, 15, bit index in the command register flagging a command error.
- POLL_GAP, 16, idle clocks between successive polls; minimum 1.
- LGTIMEOUT, 20, width of the poll-timeout counter.

Ports:
- i_clk  in  1  system clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_req_valid  in  1  command request valid.
- o_req_ready  out  1  high only in IDLE.
- i_req_cmd  in  MW  value written to ADDR_CMD.
- i_req_arg  in  MW  value written to ADDR_ARG.
- o_rsp_valid  out  1  result valid; held until accepted.
- i_rsp_ready  in  1  result accept.
- o_rsp_status  out  MW  last command-register value read.
- o_rsp_data  out  MW  value read from ADDR_RSP.
- o_rsp_err  out  1  ERR_BIT was set, or the poll timed out.
- o_rsp_timeout  out  1  the poll timed out.
- o_wb_cyc  out  1  bus cycle.
- o_wb_stb  out  1  strobe.
- o_wb_we  out  1  write enable.
- o_wb_addr  out  3  word address.
- o_wb_data  out  MW  write data.
- o_wb_sel  out  MW/8  byte selects; always all ones.
- i_wb_stall  in  1  slave stall.
- i_wb_ack  in  1  slave acknowledge.
- i_wb_data  in  MW  slave read data.

Behaviour:
- Reset, asynchronous:
  - State = IDLE.
  - o_wb_cyc, o_wb_stb, o_wb_we = 0; o_wb_addr = 0; o_wb_data = 0; o_wb_sel = all ones.
  - o_rsp_valid, o_rsp_err, o_rsp_timeout = 0; o_rsp_status, o_rsp_data = 0.
  - Reset mid-transaction drops cyc immediately; no bus cleanup.
- Bus beat rules:
  - Each beat is its own cycle.
  - cyc and stb rise together, registered.
  - stb falls on the first clock with !i_wb_stall; cyc stays high until i_wb_ack.
  - cyc falls on the ack clock.
  - Exactly one outstanding request at a time.
  - An ack arriving in the same clock as the accepted stb is legal and ends the beat.
- Request acceptance:
  - A request is accepted on i_req_valid && o_req_ready.
  - cmd and arg are latched; the latched copies drive the bus.
  - Changes on the request inputs after acceptance are ignored.
- States:
  - IDLE: o_req_ready = 1. On accept, start a write of the argument to ADDR_ARG and go to WR_ARG.
  - WR_ARG: on ack, start a write of the command to ADDR_CMD, go to WR_CMD.
  - WR_CMD: on ack, clear the timeout counter, load the gap counter with POLL_GAP, go to GAP.
  - GAP: decrement the gap counter; at 0, start a read of ADDR_CMD and go to POLL.
  - POLL, on ack:
    - Latch o_rsp_status = i_wb_data.
    - If BUSY_BIT is 0: start a read of ADDR_RSP, go to RD_RSP.
    - Else if the timeout counter is all ones: set the timeout flag and go to DONE, skipping the response read.
    - Else increment the timeout counter and go to GAP.
  - RD_RSP: on ack, latch o_rsp_data = i_wb_data, go to DONE.
  - DONE:
    - o_rsp_valid = 1.
    - o_rsp_err = status[ERR_BIT] | timeout; o_rsp_timeout = timeout.
    - Outputs are stable while valid && !ready.
    - On i_rsp_ready, drop valid and return to IDLE.
    - The next request cannot be accepted in that same clock; o_req_ready rises the following clock.
- Timeout: polls counted, not clocks. Timeout after 2^LGTIMEOUT busy polls. On timeout, o_rsp_data holds its previous value.
- Latency with zero stall and same-clock ack:
  - Each beat costs 2 clocks (cyc high, then idle).
  - A request that completes on its first poll reaches o_rsp_valid within 8+POLL_GAP clocks of acceptance.
- i_wb_data is sampled only on ack clocks in POLL and RD_RSP.

Test Plan:
- Basic: arg=0x12345678, cmd=0x0000_0048; slave reports busy=0 on the first poll, RSP=0x000001AA.
  - Required bus order: write addr1 = 0x12345678, write addr0 = 0x48, read addr0, read addr1.
  - Required result: o_rsp_valid with data=0x1AA, err=0, timeout=0.
- Busy polling: slave returns BUSY for 3 polls then clears, POLL_GAP=4.
  - Required: exactly 4 reads of addr0, each at least 4 idle clocks apart, then the response read.
- Timeout: LGTIMEOUT=3, slave always busy.
  - Required: 8 polls; o_rsp_timeout=1 and o_rsp_err=1; no read of ADDR_RSP.
- Stall/ack skew: random i_wb_stall of 0–5 clocks and ack delay of 0–7 clocks.
  - Required: stb drops on the first non-stalled clock, one request per cycle, same results as the basic test.
- Backpressure and error: final status has ERR_BIT set; hold i_rsp_ready=0 for 10 clocks.
  - Required: valid, status and err stay stable for all 10 clocks; o_req_ready=0 throughout; ready rises one clock after accept.
- Async reset asserted during WR_CMD with stb high.
  - Required: cyc, stb and valid go to 0 without waiting for a clock edge; after release, o_req_ready=1 and a new request completes normally.

Source files
------------

// File: rtl/sdio_cmd_master.sv
// sdio_cmd_master
// Wishbone pipelined bus master that runs one SDIO command from start to finish.
// The sequence is: write the argument, write the command, poll the command
// register until the busy bit clears or the poll budget runs out, then read the
// response. The result comes back on a valid/ready handshake.
//
// Ports
//   i_clk, i_reset       clock, asynchronous active-high reset
//   i_req_valid/o_req_ready, i_req_cmd, i_req_arg
//                        command request (accepted only in IDLE)
//   o_rsp_valid/i_rsp_ready, o_rsp_status, o_rsp_data, o_rsp_err, o_rsp_timeout
//                        command result, held stable until accepted
//   o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel,
//   i_wb_stall, i_wb_ack, i_wb_data
//                        Wishbone pipelined master port, one beat per bus cycle
module sdio_cmd_master #(
  parameter int         MW        = 32,
  parameter logic [2:0] ADDR_CMD  = 3'd0,
  parameter logic [2:0] ADDR_ARG  = 3'd1,
  parameter logic [2:0] ADDR_RSP  = 3'd1,
  parameter int         BUSY_BIT  = 14,
  parameter int         ERR_BIT   = 15,
  parameter int         POLL_GAP  = 16,
  parameter int         LGTIMEOUT = 20
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_req_valid,
  output logic            o_req_ready,
  input  logic [MW-1:0]   i_req_cmd,
  input  logic [MW-1:0]   i_req_arg,
  output logic            o_rsp_valid,
  input  logic            i_rsp_ready,
  output logic [MW-1:0]   o_rsp_status,
  output logic [MW-1:0]   o_rsp_data,
  output logic            o_rsp_err,
  output logic            o_rsp_timeout,
  output logic            o_wb_cyc,
  output logic            o_wb_stb,
  output logic            o_wb_we,
  output logic [2:0]      o_wb_addr,
  output logic [MW-1:0]   o_wb_data,
  output logic [MW/8-1:0] o_wb_sel,
  input  logic            i_wb_stall,
  input  logic            i_wb_ack,
  input  logic [MW-1:0]   i_wb_data
);

  localparam int GW = (POLL_GAP < 2) ? 1 : $clog2(POLL_GAP + 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(POLL_GAP);
  localparam logic [GW-1:0] GAP_ONE  = GW'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_ARG, S_WR_CMD, S_GAP, S_POLL, S_RD_RSP, S_DONE
  } state_t;

  state_t                r_state;
  logic [MW-1:0]         r_cmd;
  logic                  r_cyc;
  logic                  r_stb;
  logic                  r_we;
  logic [2:0]            r_addr;
  logic [MW-1:0]         r_wdata;
  logic [GW-1:0]         r_gap;
  logic [LGTIMEOUT-1:0]  r_tmo_cnt;
  logic                  r_rsp_valid;
  logic [MW-1:0]         r_rsp_status;
  logic [MW-1:0]         r_rsp_data;
  logic                  r_rsp_err;
  logic                  r_rsp_timeout;
  logic                  w_ack;

  // An ack only counts while our own cycle is open.
  assign w_ack = r_cyc & i_wb_ack;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_cmd         <= '0;
      r_cyc         <= 1'b0;
      r_stb         <= 1'b0;
      r_we          <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_gap         <= '0;
      r_tmo_cnt     <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_status  <= '0;
      r_rsp_data    <= '0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else begin
      // Generic beat retirement: stb drops once the slave takes it, cyc drops
      // on the ack. State-specific issue code below overrides these.
      if (r_cyc) begin
        if (r_stb && !i_wb_stall) r_stb <= 1'b0;
        if (i_wb_ack) begin
          r_cyc <= 1'b0;
          r_stb <= 1'b0;
        end
      end

      case (r_state)
        S_IDLE: begin
          if (i_req_valid) begin
            // Only the command needs keeping; the argument goes straight out.
            r_cmd   <= i_req_cmd;
            r_cyc   <= 1'b1;
            r_stb   <= 1'b1;
            r_we    <= 1'b1;
            r_addr  <= ADDR_ARG;
            r_wdata <= i_req_arg;
            r_state <= S_WR_ARG;
          end
        end

        S_WR_ARG: begin
          if (w_ack) r_state <= S_WR_CMD;
        end

        // Entered with cyc low after the previous ack, so the bus always sees
        // one idle clock between beats.
        S_WR_CMD: begin
          if (!r_cyc) begin
            r_cyc   <= 1'b1;
            r_stb   <= 1'b1;
            r_we    <= 1'b1;
            r_addr  <= ADDR_CMD;
            r_wdata <= r_cmd;
          end else if (w_ack) begin
            r_tmo_cnt <= '0;
            r_gap     <= GAP_LOAD;
            r_state   <= S_GAP;
          end
        end

        // Idle spacing between polls; the read goes out as the count expires.
        S_GAP: begin
          r_gap <= r_gap - GAP_ONE;
          if (r_gap == GAP_ONE) begin
            r_cyc   <= 1'b1;
            r_stb   <= 1'b1;
            r_we    <= 1'b0;
            r_addr  <= ADDR_CMD;
            r_state <= S_POLL;
          end
        end

        S_POLL: begin
          if (w_ack) begin
            r_rsp_status <= i_wb_data;
            if (!i_wb_data[BUSY_BIT]) begin
              r_state <= S_RD_RSP;
            end else if (&r_tmo_cnt) begin
              // Out of polls: report without reading the response register,
              // so the previous response data is left in place.
              r_rsp_valid   <= 1'b1;
              r_rsp_err     <= 1'b1;
              r_rsp_timeout <= 1'b1;
              r_state       <= S_DONE;
            end else begin
              r_tmo_cnt <= r_tmo_cnt + LGTIMEOUT'(1);
              r_gap     <= GAP_LOAD;
              r_state   <= S_GAP;
            end
          end
        end

        S_RD_RSP: begin
          if (!r_cyc) begin
            r_cyc  <= 1'b1;
            r_stb  <= 1'b1;
            r_we   <= 1'b0;
            r_addr <= ADDR_RSP;
          end else if (w_ack) begin
            r_rsp_data    <= i_wb_data;
            r_rsp_valid   <= 1'b1;
            r_rsp_err     <= r_rsp_status[ERR_BIT];
            r_rsp_timeout <= 1'b0;
            r_state       <= S_DONE;
          end
        end

        // Returning to IDLE here means o_req_ready rises the clock after the
        // handshake, never in the same clock.
        S_DONE: begin
          if (i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_req_ready   = (r_state == S_IDLE);
  assign o_rsp_valid   = r_rsp_valid;
  assign o_rsp_status  = r_rsp_status;
  assign o_rsp_data    = r_rsp_data;
  assign o_rsp_err     = r_rsp_err;
  assign o_rsp_timeout = r_rsp_timeout;
  assign o_wb_cyc      = r_cyc;
  assign o_wb_stb      = r_stb;
  assign o_wb_we       = r_we;
  assign o_wb_addr     = r_addr;
  assign o_wb_data     = r_wdata;
  assign o_wb_sel      = {(MW/8){1'b1}};

endmodule
